alu_control: RTL and testbench
==============================

# alu_control

RV32I ALU control decoder. Combines the 2-bit ALU operation class from the main control unit with the instruction's funct7 (bits 31:25) and funct3 (bits 14:12) fields. It produces a registered 4-bit operation select for the ALU. It sits between the main decoder and the ALU in the execute path.

## Interface
Parameters: none.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ALUOp_in  input  2  operation class from the main control unit:
  - 00 = load/store/address add.
  - 01 = branch compare (subtract).
  - 10 = R-type, decode funct fields.
  - 11 = reserved.
- func7  input  7  instruction bits [31:25].
- func3  input  3  instruction bits [14:12].
- AluControl_out  output  4  ALU operation select, registered.

## Operation
ALU select encoding:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SRA
- 1000 SLT
- 1001 SLTU
- Codes 1010–1111 are never produced.

Decode by ALUOp_in:
- 00 → ADD (0010). func7 and func3 are ignored.
- 01 → SUB (0110). func7 and func3 are ignored.
- 10 → R-type decode on func3, qualified by func7:
  - 000: func7=0000000 → ADD; func7=0100000 → SUB.
  - 001: func7=0000000 → SLL.
  - 010: func7=0000000 → SLT.
  - 011: func7=0000000 → SLTU.
  - 100: func7=0000000 → XOR.
  - 101: func7=0000000 → SRL; func7=0100000 → SRA.
  - 110: func7=0000000 → OR.
  - 111: func7=0000000 → AND.
  - Any other func7/func3 combination, including func7=0100000 with func3 ∉ {000,101} or func7=0000001 (M-extension), → ADD (0010).
- 11 (reserved) → ADD (0010). This is the default case.

Unknown input handling:
- All decode paths are fully specified; no latches.
- X/Z on the inputs must not propagate past reset. The decode default case selects ADD.

## Timing
- Decode is combinational. AluControl_out is a register updated on every rising clk edge with the decoded value.
- Latency: 1 cycle. Inputs applied before edge N appear on AluControl_out after edge N.
- Reset: when rst=1 at a rising edge, AluControl_out ← 0010 (ADD), regardless of the inputs. Reset has priority over the decode.
- Reset mid-operation: the next edge with rst=1 forces 0010. The first edge with rst=0 loads the current decode.
- No enable and no handshake. The output follows the inputs every cycle.
- Inputs held constant give a constant output from the cycle after the first sampling edge onward.

## Test plan
- Reset: assert rst for 2 cycles with ALUOp_in=10, func3=111 → AluControl_out=0010 throughout. First edge after deassert → 0000.
- Fixed classes: ALUOp_in=00, func7=0000000, func3=000 → 0010. ALUOp_in=01 with any func7/func3 → 0110.
- R-type logic ops: ALUOp_in=10, func7=0000000:
  - func3=111 → 0000.
  - func3=110 → 0001.
  - func3=100 → 0011.
- R-type arith, compare and shift:
  - func3=000 with func7=0000000 → 0010; with func7=0100000 → 0110.
  - func3=001 → 0100.
  - func3=010 → 1000.
  - func3=011 → 1001.
  - func3=101 with func7=0000000 → 0101; with func7=0100000 → 0111.
- Defaults:
  - ALUOp_in=11, func7=0000000, func3=000 → 0010.
  - ALUOp_in=10, func7=0000001, func3=000 → 0010.
  - ALUOp_in=10, func7=0100000, func3=111 → 0010.
- Latency: change inputs every cycle through the sequence (00,—,—) → (10,0000000,111) → (10,0000000,110) → (11,0000000,000). The output sequence 0010, 0000, 0001, 0010 must appear exactly one cycle after each input change.

Source files
------------

// File: rtl/alu_control.sv
// RV32I ALU control decoder: turns the main-decoder operation class plus funct7/funct3
// into a registered 4-bit ALU operation select.
module alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOp_in,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
  output logic [3:0] AluControl_out
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Anything outside the base/alternate funct7 encodings (e.g. M-extension) falls back to ADD.
  function automatic logic [3:0] decode_rtype(input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] sel;
    sel = OP_ADD;
    case (f7)
      F7_BASE: begin
        case (f3)
          3'b000:  sel = OP_ADD;
          3'b001:  sel = OP_SLL;
          3'b010:  sel = OP_SLT;
          3'b011:  sel = OP_SLTU;
          3'b100:  sel = OP_XOR;
          3'b101:  sel = OP_SRL;
          3'b110:  sel = OP_OR;
          3'b111:  sel = OP_AND;
          default: sel = OP_ADD;
        endcase
      end
      F7_ALT: begin
        case (f3)
          3'b000:  sel = OP_SUB;
          3'b101:  sel = OP_SRA;
          default: sel = OP_ADD;
        endcase
      end
      default: sel = OP_ADD;
    endcase
    return sel;
  endfunction

  logic [3:0] decode_s;
  logic [3:0] sel_r;

  // Combinational operation-class decode; unknown or reserved classes select ADD.
  always_comb begin
    decode_s = OP_ADD;
    case (ALUOp_in)
      2'b00:   decode_s = OP_ADD;
      2'b01:   decode_s = OP_SUB;
      2'b10:   decode_s = decode_rtype(func7, func3);
      default: decode_s = OP_ADD;
    endcase
  end

  // Output register, reloaded every cycle; reset takes priority and forces ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r <= OP_ADD;
    end else begin
      sel_r <= decode_s;
    end
  end

  assign AluControl_out = sel_r;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed cases plus randomized stimulus
// compared against a table-driven reference model.
module tb_alu_control;

  logic       clk;
  logic       rst;
  logic [1:0] ALUOp_in;
  logic [6:0] func7;
  logic [2:0] func3;
  logic [3:0] AluControl_out;

  int n_checks;
  int n_pass;
  logic [3:0] prev_exp;
  bit         prev_valid;

  alu_control dut (
    .clk            (clk),
    .rst            (rst),
    .ALUOp_in       (ALUOp_in),
    .func7          (func7),
    .func3          (func3),
    .AluControl_out (AluControl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // R-type table as listed in the instruction set: {funct7, funct3} -> ALU select.
  localparam int NR = 10;
  localparam logic [9:0] RKEY [NR] = '{
    {7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd1}, {7'h00, 3'd2}, {7'h00, 3'd3},
    {7'h00, 3'd4}, {7'h00, 3'd5}, {7'h20, 3'd5}, {7'h00, 3'd6}, {7'h00, 3'd7}
  };
  localparam logic [3:0] RVAL [NR] = '{
    4'd2, 4'd6, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd7, 4'd1, 4'd0
  };

  function automatic logic [3:0] model(input logic [1:0] op, input logic [6:0] f7,
                                       input logic [2:0] f3);
    logic [3:0] r;
    r = 4'd2;
    if (op == 2'd1) r = 4'd6;
    if (op == 2'd2) begin
      for (int k = 0; k < NR; k++)
        if (RKEY[k] == {f7, f3}) r = RVAL[k];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply one input vector, confirm the output holds until the edge, then check it after.
  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] exp;
    @(negedge clk);
    rst = r; ALUOp_in = op; func7 = f7; func3 = f3;
    #1;
    if (prev_valid) check({tag, "_hold"}, AluControl_out, prev_exp);
    exp = r ? 4'd2 : model(op, f7, f3);
    @(posedge clk);
    #1;
    check(tag, AluControl_out, exp);
    prev_exp = exp;
    prev_valid = 1'b1;
  endtask

  initial begin
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       r;
    n_checks = 0; n_pass = 0; prev_valid = 1'b0; prev_exp = 4'd0;
    rst = 1'b1; ALUOp_in = 2'b10; func7 = 7'd0; func3 = 3'b111;

    // Reset with an AND decode pending, then release.
    step("reset0", 1'b1, 2'b10, 7'h00, 3'b111);
    step("reset1", 1'b1, 2'b10, 7'h00, 3'b111);
    step("post_reset_and", 1'b0, 2'b10, 7'h00, 3'b111);

    // Fixed classes.
    step("ld_add", 1'b0, 2'b00, 7'h00, 3'b000);
    step("br_sub", 1'b0, 2'b01, 7'h5a, 3'b011);
    step("br_sub2", 1'b0, 2'b01, 7'h20, 3'b101);

    // R-type table.
    step("r_and", 1'b0, 2'b10, 7'h00, 3'b111);
    step("r_or", 1'b0, 2'b10, 7'h00, 3'b110);
    step("r_xor", 1'b0, 2'b10, 7'h00, 3'b100);
    step("r_add", 1'b0, 2'b10, 7'h00, 3'b000);
    step("r_sub", 1'b0, 2'b10, 7'h20, 3'b000);
    step("r_sll", 1'b0, 2'b10, 7'h00, 3'b001);
    step("r_slt", 1'b0, 2'b10, 7'h00, 3'b010);
    step("r_sltu", 1'b0, 2'b10, 7'h00, 3'b011);
    step("r_srl", 1'b0, 2'b10, 7'h00, 3'b101);
    step("r_sra", 1'b0, 2'b10, 7'h20, 3'b101);

    // Defaults.
    step("rsvd_add", 1'b0, 2'b11, 7'h00, 3'b000);
    step("mext_add", 1'b0, 2'b10, 7'h01, 3'b000);
    step("alt_and_add", 1'b0, 2'b10, 7'h20, 3'b111);

    // Latency sequence: one new vector per cycle.
    step("lat0", 1'b0, 2'b00, 7'h7f, 3'b111);
    step("lat1", 1'b0, 2'b10, 7'h00, 3'b111);
    step("lat2", 1'b0, 2'b10, 7'h00, 3'b110);
    step("lat3", 1'b0, 2'b11, 7'h00, 3'b000);

    // Mid-stream reset then recovery.
    step("mid_rst", 1'b1, 2'b10, 7'h20, 3'b101);
    step("mid_rel", 1'b0, 2'b10, 7'h20, 3'b101);

    // Randomized, biased toward meaningful funct7 values.
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      if ($urandom_range(0, 2) != 0) op = 2'b10;
      f3 = 3'($urandom);
      r  = ($urandom_range(0, 15) == 0);
      step("rand", r, op, f7, f3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
